explosion_ctrl: RTL and testbench
=================================

// Module: explosion_ctrl
// PURPOSE
//  Single-blast explosion controller; sits directly upstream of explosion_rom.
//  Latches a bomb detonation (center tile + range) and times its lifetime in frames.
//  Per VGA pixel, tests the pixel against the cross-shaped blast area and drives the ROM address.
//  Uses the ROM colour to produce an overlay pixel plus a blast-done event for block destruction.
// PARAMETERS
//  BLAST_TICKS  60        frames the blast stays visible (>=1)
//  MAX_RANGE    3         max arm length in tiles; det_range is clamped to this
//  TRANSP       12'h000   ROM colour treated as transparent (exp_on forced low)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   synchronous active-low reset
//  frame_tick   in   1   one-cycle pulse per video frame
//  det_req      in   1   detonation request; accepted when det_req && det_ready
//  det_tx       in   5   blast center tile column (0..19)
//  det_ty       in   5   blast center tile row (0..14)
//  det_range    in   2   arm length in tiles
//  det_ready    out  1   high only in IDLE
//  video_on     in   1   pixel is in the visible area
//  x            in  10   pixel column
//  y            in  10   pixel row
//  rom_row      out  5   to explosion_rom row (= y[4:0])
//  rom_col      out  5   to explosion_rom col (= x[4:0])
//  rom_color    in  12   from explosion_rom color_data (1 cycle after rom_row/rom_col)
//  exp_on       out  1   overlay pixel valid
//  exp_rgb      out 12   overlay colour (0 when exp_on low)
//  blast_active out  1   high in ACTIVE
//  blast_done   out  1   one-cycle pulse when a blast expires normally
// BEHAVIOUR
//  Reset: state=IDLE, tick_cnt=0, latched center/range=0, hit_d1=0.
//   Outputs after reset: exp_on=0, exp_rgb=0, blast_active=0, blast_done=0, det_ready=1.
//  FSM:
//   - IDLE -> ACTIVE on det_req: latch det_tx/det_ty; range_eff = clamp(det_range, 1, MAX_RANGE) (0 reads as 1).
//   - ACTIVE: tick_cnt += 1 on each frame_tick. Leave for DONE on frame_tick when tick_cnt == BLAST_TICKS-1.
//   - DONE: blast_done=1 for exactly this cycle -> IDLE.
//  Handshake / timing:
//   - det_req outside IDLE is ignored; no queue. det_ready is low in ACTIVE and DONE.
//   - A frame_tick coincident with the accepting cycle is not counted.
//  Hit test (combinational on x, y; tile tx=x[9:5], ty=y[9:5]):
//   hit = blast_active && video_on &&
//         ((ty==cy && |tx-cx|<=range_eff) || (tx==cx && |ty-cy|<=range_eff))
//   - Differences are computed 6-bit signed; no wrap-around at the arena edges.
//   - Tiles outside 0..19 / 0..14 never hit.
//  Pipeline:
//   - rom_row/rom_col are combinational from y/x in the same cycle.
//   - hit is registered into hit_d1, so it aligns with the ROM's 1-cycle registered address.
//   - exp_on = hit_d1 && rom_color != TRANSP; exp_rgb = exp_on ? rom_color : 0.
//   - Latency: result for pixel presented in cycle n appears in cycle n+1.
//  Boundaries:
//   - When the blast ends (DONE), hit_d1 still carries the last ACTIVE pixel for one cycle; that pixel is shown.
//   - reset_n low mid-blast returns to IDLE, clears hit_d1, and emits no blast_done.
// TESTING
//  1. After reset: det_req=1, tx=5, ty=4, range=2 -> next cycle blast_active=1, det_ready=0.
//  2. x=163, y=135 -> same cycle rom_row=7, rom_col=3; next cycle exp_on=1, exp_rgb=rom_color.
//  3. Hit pattern with that blast:
//     - tiles (7,4) and (5,6) -> exp_on=1;
//     - tiles (8,4), (6,5) and (5,7) -> exp_on=0;
//     - rom_color=12'h000 on a hit tile -> exp_on=0, exp_rgb=0.
//  4. Edge blast tx=0, ty=0, range=3 (MAX_RANGE=3):
//     - tiles (0..3,0) and (0,0..3) -> lit;
//     - x=639 (tile 19) -> exp_on=0 (no wrap).
//  5. BLAST_TICKS=4: after the 4th frame_tick, blast_done=1 for exactly one cycle, then det_ready=1.
//     A det_req during ACTIVE is ignored; a det_range=0 request lights only the center +/-1 tile.
//  6. reset_n=0 for one cycle mid-blast -> next cycle exp_on=0, blast_active=0, det_ready=1; blast_done never pulses.

Source files
------------

// File: rtl/explosion_ctrl.sv
// explosion_ctrl
// Single-blast explosion controller that sits directly upstream of explosion_rom.
// It latches one bomb detonation (center tile and arm length) and counts the
// blast lifetime in video frames. For each VGA pixel it tests whether the pixel
// lies inside the cross-shaped blast, and it drives the ROM address. It then
// combines the ROM colour with the registered hit into an overlay pixel. It also
// pulses blast_done when a blast expires normally, for block destruction.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   frame_tick                one-cycle pulse per video frame
//   det_req/det_ready         detonation handshake (accepted only in IDLE)
//   det_tx, det_ty, det_range blast center tile and requested arm length
//   video_on, x, y            current pixel
//   rom_row, rom_col          explosion_rom address (pixel offset inside tile)
//   rom_color                 explosion_rom colour, one cycle after the address
//   exp_on, exp_rgb           overlay pixel valid / colour
//   blast_active, blast_done  blast visible / one-cycle expiry pulse
module explosion_ctrl #(
   parameter int          BLAST_TICKS = 60,
   parameter int          MAX_RANGE   = 3,
   parameter logic [11:0] TRANSP      = 12'h000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic        det_req,
   input  logic [4:0]  det_tx,
   input  logic [4:0]  det_ty,
   input  logic [1:0]  det_range,
   output logic        det_ready,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [4:0]  rom_row,
   output logic [4:0]  rom_col,
   input  logic [11:0] rom_color,
   output logic        exp_on,
   output logic [11:0] exp_rgb,
   output logic        blast_active,
   output logic        blast_done
);

   localparam int CNT_W = (BLAST_TICKS > 1) ? $clog2(BLAST_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] tick_cnt;
   logic [4:0]       cx;
   logic [4:0]       cy;
   logic [1:0]       range_eff;

   logic [4:0]        tx;
   logic [4:0]        ty;
   logic signed [5:0] dx;
   logic signed [5:0] dy;
   logic [5:0]        adx;
   logic [5:0]        ady;
   logic              in_arena;
   logic              hit;
   logic              hit_p1;

   // A requested arm length of 0 still lights the adjacent tiles.
   function automatic logic [1:0] clamp_range(input logic [1:0] r);
      if (r == 2'd0)
         return 2'd1;
      if (int'(r) > MAX_RANGE)
         return 2'(MAX_RANGE);
      return r;
   endfunction

   function automatic logic [5:0] abs6(input logic signed [5:0] v);
      return (v < 0) ? 6'(-v) : 6'(v);
   endfunction

   // Control FSM, outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         tick_cnt     <= '0;
         cx           <= '0;
         cy           <= '0;
         range_eff    <= '0;
         det_ready    <= 1'b1;
         blast_active <= 1'b0;
         blast_done   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (det_req) begin
                  state        <= S_ACTIVE;
                  cx           <= det_tx;
                  cy           <= det_ty;
                  range_eff    <= clamp_range(det_range);
                  tick_cnt     <= '0;
                  det_ready    <= 1'b0;
                  blast_active <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (frame_tick) begin
                  if (tick_cnt == CNT_W'(BLAST_TICKS - 1)) begin
                     state        <= S_DONE;
                     tick_cnt     <= '0;
                     blast_active <= 1'b0;
                     blast_done   <= 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               blast_done <= 1'b0;
               det_ready  <= 1'b1;
            end
            default: begin
               state        <= S_IDLE;
               det_ready    <= 1'b1;
               blast_active <= 1'b0;
               blast_done   <= 1'b0;
            end
         endcase
      end
   end

   // Stage 0: combinational cross-shaped hit test on the current pixel
   always_comb begin
      tx       = x[9:5];
      ty       = y[9:5];
      dx       = $signed({1'b0, tx}) - $signed({1'b0, cx});
      dy       = $signed({1'b0, ty}) - $signed({1'b0, cy});
      adx      = abs6(dx);
      ady      = abs6(dy);
      in_arena = (tx <= 5'd19) && (ty <= 5'd14);
      hit      = blast_active && video_on && in_arena &&
                 (((ty == cy) && (adx <= {4'b0, range_eff})) ||
                  ((tx == cx) && (ady <= {4'b0, range_eff})));
   end

   assign rom_row = y[4:0];
   assign rom_col = x[4:0];

   // Stage 1: hit delayed to line up with the ROM's registered colour
   always_ff @(posedge clk) begin
      if (!reset_n)
         hit_p1 <= 1'b0;
      else
         hit_p1 <= hit;
   end

   assign exp_on  = hit_p1 && (rom_color != TRANSP);
   assign exp_rgb = exp_on ? rom_color : 12'h000;

endmodule

// File: tb/tb_explosion_ctrl.sv
module tb_explosion_ctrl;

   localparam int BT = 4;
   localparam int MR = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        det_req = 1'b0;
   logic [4:0]  det_tx = '0;
   logic [4:0]  det_ty = '0;
   logic [1:0]  det_range = '0;
   logic        det_ready;
   logic        video_on = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic [4:0]  rom_row;
   logic [4:0]  rom_col;
   logic [11:0] rom_color = '0;
   logic        exp_on;
   logic [11:0] exp_rgb;
   logic        blast_active;
   logic        blast_done;

   explosion_ctrl #(.BLAST_TICKS(BT), .MAX_RANGE(MR), .TRANSP(12'h000)) dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .det_req(det_req), .det_tx(det_tx), .det_ty(det_ty), .det_range(det_range),
      .det_ready(det_ready), .video_on(video_on), .x(x), .y(y),
      .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
      .exp_on(exp_on), .exp_rgb(exp_rgb),
      .blast_active(blast_active), .blast_done(blast_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       active;
      bit       done;
      bit       ready;
      bit       on;
      int       rgb;
      int       row;
      int       col;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: blast described as "alive / just expired", center, reach,
   // frames seen so far, and whether the previous pixel was inside the cross.
   bit m_valid = 0;
   bit m_active = 0;
   bit m_done = 0;
   bit m_hit1 = 0;
   int m_cx = 0, m_cy = 0, m_r = 1, m_frames = 0;

   function automatic bit in_cross(int xx, int yy);
      int tx, ty, dx, dy;
      tx = xx / 32;
      ty = yy / 32;
      if (tx > 19 || ty > 14) return 0;
      dx = (tx > m_cx) ? tx - m_cx : m_cx - tx;
      dy = (ty > m_cy) ? ty - m_cy : m_cy - ty;
      return (ty == m_cy && dx <= m_r) || (tx == m_cx && dy <= m_r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("blast_active", 32'(blast_active), 32'(e.active));
         chk("blast_done",   32'(blast_done),   32'(e.done));
         chk("det_ready",    32'(det_ready),    32'(e.ready));
         chk("exp_on",       32'(exp_on),       32'(e.on));
         chk("exp_rgb",      32'(exp_rgb),      32'(e.rgb));
         chk("rom_row",      32'(rom_row),      32'(e.row));
         chk("rom_col",      32'(rom_col),      32'(e.col));
      end
   end

   // One clock cycle of stimulus; the expected outputs for this cycle are
   // queued, then the model advances to the state after the next edge.
   task automatic step(input bit rn, input bit dq, input int tx, input int ty,
                       input int rg, input bit ft, input bit vo,
                       input int xx, input int yy, input int rc);
      exp_t e;
      bit   nh;
      @(posedge clk);
      #1;
      reset_n    = rn;
      det_req    = dq;
      det_tx     = 5'(tx);
      det_ty     = 5'(ty);
      det_range  = 2'(rg);
      frame_tick = ft;
      video_on   = vo;
      x          = 10'(xx);
      y          = 10'(yy);
      rom_color  = 12'(rc);
      if (m_valid) begin
         e.active = m_active;
         e.done   = m_done;
         e.ready  = !m_active && !m_done;
         e.on     = m_hit1 && (rc != 0);
         e.rgb    = e.on ? rc : 0;
         e.row    = yy % 32;
         e.col    = xx % 32;
         q.push_back(e);
      end
      nh = m_active && vo && in_cross(xx, yy);
      if (!rn) begin
         m_valid = 1; m_active = 0; m_done = 0; m_hit1 = 0;
         m_cx = 0; m_cy = 0; m_r = 1; m_frames = 0;
      end else begin
         m_hit1 = nh;
         if (m_done) begin
            m_done = 0;
         end else if (m_active) begin
            if (ft) begin
               m_frames++;
               if (m_frames == BT) begin
                  m_active = 0;
                  m_done   = 1;
               end
            end
         end else if (dq) begin
            m_active = 1;
            m_cx = tx; m_cy = ty;
            m_r = (rg == 0) ? 1 : ((rg > MR) ? MR : rg);
            m_frames = 0;
         end
      end
   endtask

   task automatic pix(input int tx, input int ty, input int rc);
      step(1, 0, 0, 0, 0, 0, 1, tx * 32 + 3, ty * 32 + 7, rc);
   endtask

   task automatic idle_cycle(input bit ft);
      step(1, 0, 0, 0, 0, ft, 0, 0, 0, 12'h123);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_cycle(0);

      // blast at (5,4), range 2; frame_tick on the accepting cycle is ignored
      step(1, 1, 5, 4, 2, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 163, 135, 12'h0F0);
      pix(7, 4, 12'hABC);
      pix(5, 6, 12'h456);
      pix(8, 4, 12'h789);
      pix(6, 5, 12'h321);
      pix(5, 7, 12'h111);
      pix(5, 2, 12'h222);
      pix(3, 4, 12'h333);
      pix(4, 4, 12'h444);
      step(1, 1, 10, 10, 3, 0, 1, 5 * 32, 4 * 32, 12'h000);
      pix(10, 10, 12'h000);
      // four frame ticks end the blast; last ACTIVE pixel still shown in DONE
      step(1, 0, 0, 0, 0, 1, 1, 5 * 32 + 1, 4 * 32 + 1, 12'h555);
      step(1, 0, 0, 0, 0, 1, 1, 5 * 32 + 2, 4 * 32 + 2, 12'h666);
      step(1, 0, 0, 0, 0, 1, 1, 5 * 32 + 3, 4 * 32 + 3, 12'h777);
      step(1, 0, 0, 0, 0, 1, 1, 5 * 32 + 4, 4 * 32 + 4, 12'h888);
      pix(5, 4, 12'h999);
      pix(5, 4, 12'hAAA);
      idle_cycle(0);

      // edge blast at (0,0), range 3
      step(1, 1, 0, 0, 3, 0, 0, 0, 0, 0);
      for (int i = 0; i <= 4; i++) pix(i, 0, 12'hF00 + i);
      for (int j = 0; j <= 4; j++) pix(0, j, 12'h0F0 + j);
      step(1, 0, 0, 0, 0, 0, 1, 639, 5, 12'h00F);
      step(1, 0, 0, 0, 0, 0, 1, 5, 479, 12'h00E);
      step(1, 0, 0, 0, 0, 0, 0, 40, 5, 12'h00D);
      pix(1, 0, 12'hBEE);
      for (int i = 0; i < BT; i++) idle_cycle(1);
      idle_cycle(0);
      idle_cycle(0);

      // range 0 reads as 1
      step(1, 1, 10, 7, 0, 0, 0, 0, 0, 0);
      pix(11, 7, 12'h001);
      pix(12, 7, 12'h002);
      pix(10, 8, 12'h003);
      pix(10, 9, 12'h004);
      pix(9, 7, 12'h005);
      pix(10, 7, 12'h006);

      // reset mid-blast: no blast_done, hit pipeline cleared
      step(0, 0, 0, 0, 0, 0, 1, 10 * 32, 7 * 32, 12'h007);
      pix(10, 7, 12'h008);
      for (int i = 0; i < 6; i++) idle_cycle(1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int xx, yy, rc;
         bit rn, dq, ft, vo;
         rn = ($urandom_range(0, 199) != 0);
         dq = ($urandom_range(0, 7) == 0);
         ft = ($urandom_range(0, 3) == 0);
         vo = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) begin
            xx = (m_cx + $urandom_range(0, 8) - 4) * 32 + $urandom_range(0, 31);
            yy = (m_cy + $urandom_range(0, 8) - 4) * 32 + $urandom_range(0, 31);
            if (xx < 0 || xx > 1023) xx = $urandom_range(0, 1023);
            if (yy < 0 || yy > 1023) yy = $urandom_range(0, 1023);
         end else begin
            xx = $urandom_range(0, 1023);
            yy = $urandom_range(0, 1023);
         end
         rc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095);
         step(rn, dq, $urandom_range(0, 19), $urandom_range(0, 14),
              $urandom_range(0, 3), ft, vo, xx, yy, rc);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
